// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: single-cycle pipeline results take priority,
// mul/div results wait in a small FIFO, and a busy scoreboard tracks pending writes.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Pwe,
  input  logic [4:0]  Pwn,
  input  logic [31:0] Pd,
  input  logic        Mvalid,
  input  logic [4:0]  Mwn,
  input  logic [31:0] Md,
  output logic        Mready,
  input  logic        Iss,
  input  logic [4:0]  Iwn,
  input  logic [4:0]  Ra,
  input  logic [4:0]  Rb,
  output logic        Busya,
  output logic        Busyb,
  output logic        Busyw,
  output logic        Hold,
  output logic [1:0]  Cnt,
  output logic [4:0]  Wn,
  output logic [31:0] D,
  output logic        We
);

  logic [4:0]  fifo_wn [DEPTH];
  logic [31:0] fifo_d  [DEPTH];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] busy;
  logic [31:0] busy_nxt;

  logic pipe_claim;
  logic push;
  logic pop;
  logic full;

  assign full       = (Cnt == 2'(DEPTH));
  assign pipe_claim = Pwe && (Pwn != 5'd0);
  assign pop        = !pipe_claim && (Cnt != 2'd0);
  assign Mready     = !Clr && !full;
  assign push       = Mvalid && Mready;
  assign Hold       = full;

  // Bit 0 is never set, so register 0 always reads as not busy.
  assign Busya = busy[Ra];
  assign Busyb = busy[Rb];
  assign Busyw = busy[Iwn];

  // Clear for the popped destination first so a same-edge issue wins.
  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    busy_nxt = busy;
    if (pop && fifo_wn[rd_ptr] != 5'd0) busy_nxt[fifo_wn[rd_ptr]] = 1'b0;
    if (Iss && Iwn != 5'd0)             busy_nxt[Iwn] = 1'b1;
  end

  // NOTE: FIFO storage has no reset; Cnt and the pointers decide which entries are live.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_wn[wr_ptr] <= Mwn;
      fifo_d[wr_ptr]  <= Md;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      Cnt    <= 2'd0;
      busy   <= '0;
      We     <= 1'b0;
      Wn     <= 5'd0;
      D      <= 32'd0;
    end else begin
      if (pipe_claim) begin
        We <= 1'b1;
        Wn <= Pwn;
        D  <= Pd;
      end else if (pop) begin
        We <= (fifo_wn[rd_ptr] != 5'd0);
        Wn <= fifo_wn[rd_ptr];
        D  <= fifo_d[rd_ptr];
      end else begin
        We <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      Cnt <= Cnt + 2'd1;
      else if (pop && !push) Cnt <= Cnt - 2'd1;

      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic, all checked
// against a queue-based model of the write-back rules.
module tb_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Clr, Pwe, Mvalid, Iss;
  logic [4:0]  Pwn, Mwn, Iwn, Ra, Rb;
  logic [31:0] Pd, Md;
  logic        Mready, Busya, Busyb, Busyw, Hold, We;
  logic [1:0]  Cnt;
  logic [4:0]  Wn;
  logic [31:0] D;

  int checks   = 0;
  int failures = 0;

  wb_arbiter #(.DEPTH(2)) dut (
    .Clk(Clk), .Clr(Clr), .Pwe(Pwe), .Pwn(Pwn), .Pd(Pd),
    .Mvalid(Mvalid), .Mwn(Mwn), .Md(Md), .Mready(Mready),
    .Iss(Iss), .Iwn(Iwn), .Ra(Ra), .Rb(Rb),
    .Busya(Busya), .Busyb(Busyb), .Busyw(Busyw),
    .Hold(Hold), .Cnt(Cnt), .Wn(Wn), .D(D), .We(We)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  wn;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  bit   [31:0] mbusy;
  logic        m_we;
  logic [4:0]  m_wn;
  logic [31:0] m_d;
  bit          m_known = 0;
  bit          m_was_reset;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input logic [4:0] r);
    return (r != 5'd0) && mbusy[r];
  endfunction

  // One clock: check combinational outputs, advance model across the edge, check registered outputs.
  task automatic step();
    bit   accept;
    ent_t e;
    #1;
    if (m_known) begin
      check("mready", Mready, 32'(!Clr && mq.size() != 2));
      check("hold",   Hold,   32'(mq.size() == 2));
      check("cnt",    Cnt,    32'(mq.size()));
      check("busya",  Busya,  32'(busy_of(Ra)));
      check("busyb",  Busyb,  32'(busy_of(Rb)));
      check("busyw",  Busyw,  32'(busy_of(Iwn)));
    end
    @(posedge Clk);
    m_was_reset = 0;
    if (Clr) begin
      mq.delete();
      mbusy = '0;
      m_we = 0; m_wn = 0; m_d = 0;
      m_known = 1;
      m_was_reset = 1;
    end else begin
      accept = Mvalid && mq.size() < 2;
      if (Pwe && Pwn != 5'd0) begin
        m_we = 1; m_wn = Pwn; m_d = Pd;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = (e.wn != 5'd0); m_wn = e.wn; m_d = e.d;
        if (e.wn != 5'd0) mbusy[e.wn] = 1'b0;
      end else begin
        m_we = 0;
      end
      if (Iss && Iwn != 5'd0) mbusy[Iwn] = 1'b1;
      if (accept) mq.push_back('{wn: Mwn, d: Md});
    end
    #1;
    if (m_known) begin
      check("we", We, 32'(m_we));
      if (m_we || m_was_reset) begin
        check("wn", Wn, 32'(m_wn));
        check("d",  D,  m_d);
      end
    end
  endtask

  task automatic set_idle();
    Clr = 0; Pwe = 0; Pwn = 0; Pd = 0;
    Mvalid = 0; Mwn = 0; Md = 0; Iss = 0; Iwn = 0;
  endtask

  task automatic scan_busy_clear(input string tag);
    for (int r = 0; r < 32; r++) begin
      Ra = 5'(r); Rb = 5'(31 - r);
      step();
      check(tag, Busya, 32'd0);
    end
  endtask

  initial begin
    set_idle();
    Ra = 0; Rb = 0;

    // Reset then idle
    Clr = 1;
    step(); step();
    check("rst_we", We, 32'd0);
    check("rst_cnt", Cnt, 32'd0);
    check("rst_mready_during", Mready, 32'd0);
    Clr = 0;
    #1;
    check("rst_mready_after", Mready, 32'd1);
    scan_busy_clear("idle_busya");

    // Pipeline only
    Pwe = 1; Pwn = 5; Pd = 32'h1234_5678;
    step();
    check("pipe_we", We, 32'd1);
    check("pipe_wn", Wn, 32'd5);
    check("pipe_d",  D,  32'h1234_5678);
    Pwn = 0; Pd = 32'hFFFF_FFFF;
    step();
    check("pipe_r0_we", We, 32'd0);
    set_idle();

    // Mul/div with idle pipeline
    Iss = 1; Iwn = 9; Ra = 9;
    step();
    check("md_busy_set", Busya, 32'd1);
    Iss = 0; Mvalid = 1; Mwn = 9; Md = 32'hDEAD_BEEF;
    step();
    check("md_no_bypass_we", We, 32'd0);
    Mvalid = 0;
    step();
    check("md_we", We, 32'd1);
    check("md_wn", Wn, 32'd9);
    check("md_d",  D,  32'hDEAD_BEEF);
    check("md_busy_clr", Busya, 32'd0);
    step();
    check("md_we_pulse", We, 32'd0);

    // Contention and full
    Iss = 1; Iwn = 3; step();
    Iwn = 4; step();
    Iwn = 6; step();
    Iss = 0;
    Pwe = 1; Pwn = 7; Pd = 32'h0000_0077;
    Mvalid = 1; Mwn = 3; Md = 32'h3333_3333; step();
    Mwn = 4; Md = 32'h4444_4444; step();
    Mwn = 6; Md = 32'h6666_6666; step();
    step();
    check("full_hold",   Hold,   32'd1);
    check("full_cnt",    Cnt,    32'd2);
    check("full_mready", Mready, 32'd0);
    check("full_wn",     Wn,     32'd7);
    Pwe = 0;
    step();
    check("drain0_wn", Wn, 32'd3);
    check("drain0_d",  D,  32'h3333_3333);
    step();
    check("drain1_wn", Wn, 32'd4);
    Mvalid = 0;
    step();
    check("drain2_wn", Wn, 32'd6);
    check("drain2_d",  D,  32'h6666_6666);
    step();
    check("drain_done_we", We, 32'd0);
    set_idle();

    // Same-edge set and clear
    Iss = 1; Iwn = 8; step();
    Iss = 0; Mvalid = 1; Mwn = 8; Md = 32'h0808_0808; step();
    Mvalid = 0; Iss = 1; Iwn = 8; Ra = 8;
    step();
    check("setclr_we", We, 32'd1);
    check("setclr_busy", Busya, 32'd1);
    Iss = 0; Mvalid = 1; Md = 32'h0808_0809; step();
    Mvalid = 0; step();
    check("setclr_busy_final", Busya, 32'd0);

    // Register-0 mul/div entry: accepted, popped, no write
    Mvalid = 1; Mwn = 0; Md = 32'h0BAD_0BAD; step();
    Mvalid = 0; step();
    check("r0_md_we", We, 32'd0);

    // Reset mid-operation
    Iss = 1; Iwn = 12; Ra = 12; step();
    Iss = 0; Pwe = 1; Pwn = 7;
    Mvalid = 1; Mwn = 10; Md = 32'hA0A0_A0A0; step();
    Mwn = 11; Md = 32'hB1B1_B1B1; step();
    Mvalid = 0;
    check("mid_cnt_full", Cnt, 32'd2);
    check("mid_busy_set", Busya, 32'd1);
    Pwe = 0; Clr = 1; step();
    Clr = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_no_we", We, 32'd0);
    end
    check("mid_cnt", Cnt, 32'd0);
    scan_busy_clear("mid_busya");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      Clr    = ($urandom_range(0, 79) == 0);
      Pwe    = ($urandom_range(0, 2) == 0);
      Pwn    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      Pd     = $urandom;
      Mvalid = $urandom_range(0, 1) == 1;
      Mwn    = 5'($urandom_range(0, 31));
      Md     = $urandom;
      Iwn    = 5'($urandom_range(0, 31));
      Iss    = ($urandom_range(0, 2) == 0) && !busy_of(Iwn);
      Ra     = 5'($urandom_range(0, 31));
      Rb     = 5'($urandom_range(0, 31));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that owns the single write port of the CPU register file. It merges single-cycle pipeline write-back results with out-of-order results from the multi-cycle multiply/divide unit, buffers the latter in a 2-entry FIFO, and drives registered `Wn`/`D`/`We` into the register file. It also keeps a 31-bit busy scoreboard of registers awaiting long-latency results, which decode uses for hazard stalls.

## Interface

Parameters:
- `DEPTH`, 2: mul/div result FIFO entries (fixed at 2; occupancy port sized for it).

Ports:
- `Clk` in 1: clock; all state updates on posedge.
- `Clr` in 1: reset; synchronous, active-high.
- `Pwe` in 1: pipeline write-back enable.
- `Pwn` in 5: pipeline destination register.
- `Pd` in 32: pipeline write data.
- `Mvalid` in 1: mul/div result valid.
- `Mwn` in 5: mul/div destination register.
- `Md` in 32: mul/div result data.
- `Mready` out 1: FIFO can accept; transfer when `Mvalid && Mready` at posedge.
- `Iss` in 1: long-latency op issued this cycle.
- `Iwn` in 5: destination of issued op.
- `Ra`, `Rb` in 5 each: decode source registers.
- `Busya`, `Busyb`, `Busyw` out 1 each: scoreboard bit for `Ra`, `Rb`, `Iwn`.
- `Hold` out 1: FIFO full; upstream must bubble write-back.
- `Cnt` out 2: FIFO occupancy, 0..2.
- `Wn` out 5, `D` out 32, `We` out 1: registered register-file write port.

## Operation

- Pipeline priority: pipeline write-back cannot stall, so `Pwe && Pwn != 0` always claims the write port.
- FIFO drain: on any edge where the pipeline does not claim the port (`Pwe == 0` or `Pwn == 0`) and `Cnt != 0`, the FIFO head is popped and registered onto `Wn`/`D` with `We = 1`.
- No bypass: a result pushed at edge t is at the earliest popped at edge t+1.
- Push and pop on the same edge are legal. `Cnt` is unchanged and FIFO order is preserved.
- `Mready = !Clr && Cnt != 2`. `Hold = (Cnt == 2)`.
- If `Pwe` stays high while `Hold` is asserted, the pipeline still wins and the FIFO keeps its contents. Nothing is lost, because `Mready == 0`.
- Register 0:
  - Pipeline writes with `Pwn == 0` are dropped.
  - A mul/div entry with `Mwn == 0` is accepted and popped, but produces `We = 0`.
  - `Busya`/`Busyb`/`Busyw` are 0 for register 0.
- Scoreboard `busy[1:31]`:
  - `Iss && Iwn != 0` sets `busy[Iwn]`.
  - The edge that registers a FIFO pop with `Wn != 0` clears `busy[Wn]`.
  - If set and clear target the same register on the same edge, set wins.
  - Pipeline writes never touch the scoreboard (WAW against a busy register is legal; the busy bit stays).
  - Issuing to a register with `Busyw == 1` is illegal. Decode must stall; the block does no counting.
- `Busya = busy[Ra]`, `Busyb = busy[Rb]`, `Busyw = busy[Iwn]`, all combinational.
- `Clr`: on the edge it is sampled, the FIFO is flushed, `Cnt = 0`, all busy bits cleared, `We = 0`, `Wn = 0`, `D = 0`. Results in flight are discarded; reset mid-operation has no other effect.

## Timing

- Reset values: `We = 0`, `Wn = 0`, `D = 0`, `Cnt = 0`, `Hold = 0`, `Mready = 0` while `Clr` is high and 1 after, all busy outputs 0.
- Pipeline latency: `Pwe`/`Pwn`/`Pd` sampled at edge t, so `We`/`Wn`/`D` are valid in the cycle after t. The register file commits at edge t+1.
- Mul/div latency: at least 2 edges. Accepted at t, popped at t+1 if the port is idle, and `We` is high in the cycle after t+1.
- `We` is a single-cycle pulse per write. It drops to 0 on any edge with no pipeline write and no pop.
- Busy clears at the pop edge, so `Busya` falls in the same cycle that `We`/`Wn` present the result. Decode must still use register-file write-through or forwarding for that cycle.
- Maximum throughput: one register-file write per cycle.

## Test plan

- Reset then idle: assert `Clr` for 2 cycles → `We = 0`, `Cnt = 0`, `Mready = 1` after release, `Busya = 0` for all `Ra`.
- Pipeline only: `Pwe = 1`, `Pwn = 5`, `Pd = 0x12345678` at edge t → `We = 1`, `Wn = 5`, `D = 0x12345678` in cycle t+1. With `Pwn = 0` → `We = 0`.
- Mul/div with idle pipeline: `Iss`, `Iwn = 9`, so `Busya = 1` for `Ra = 9`. Then `Mvalid`, `Mwn = 9`, `Md = 0xDEADBEEF` accepted at t → `We = 1`, `Wn = 9`, `D = 0xDEADBEEF` after edge t+1, and `Busya = 0` after edge t+1.
- Contention and full:
  - Stimulus: push 3 mul/div results (r3, r4, r6) back-to-back while `Pwe = 1` continuously with `Pwn = 7`.
  - Required: `Cnt` reaches 2, `Hold = 1`, `Mready = 0`, third result held off, only r7 written.
  - Then drop `Pwe`: r3, r4, r6 written on consecutive cycles in order.
- Same-edge set/clear: pop of r8 coincides with `Iss`, `Iwn = 8` → `busy[8]` remains 1.
- Reset mid-operation: with `Cnt = 2` and busy bits set, pulse `Clr` → `Cnt = 0`, no further `We` for the flushed entries, all busy bits 0.
